// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - iterative normalize and round-to-nearest-even stage for FP add/sub
// One normalization shift per cycle, then a single rounding cycle into held output registers.
module fp_normalize_round #(
  parameter int MANTISSA_WIDTH = 23,
  parameter int EXP_WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MANTISSA_WIDTH+3:0]   sum,
  input  logic                        carry,
  input  logic                        sum_neg,
  input  logic                        sign_in,
  input  logic [EXP_WIDTH-1:0]        exp_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_sign,
  output logic [EXP_WIDTH-1:0]        out_exp,
  output logic [MANTISSA_WIDTH-1:0]   out_frac,
  output logic                        out_overflow,
  output logic                        out_zero
);

  localparam int MW   = MANTISSA_WIDTH;
  localparam int MAGW = MANTISSA_WIDTH + 5;
  localparam int EW1  = EXP_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t state_q, state_d;

  logic [MAGW-1:0] mag_q;
  logic [EW1-1:0]  e_q;
  logic            sgn_q;
  logic            zero_q;

  logic [MAGW-1:0] raw_in, mag_in;
  logic            mag_is_zero, mag_ovf, mag_hid, e_gt1;
  logic            rnd_lsb, rnd_g, rnd_rs, rnd_inc;
  logic [MW+1:0]   f_raw;
  logic [MW:0]     f_norm;
  logic [EW1-1:0]  e_rnd;
  logic            ovf_rnd;
  logic [EXP_WIDTH-1:0] exp_field;

  assign raw_in = {carry, sum};
  assign mag_in = sum_neg ? (~raw_in + MAGW'(1)) : raw_in;

  assign mag_is_zero = (mag_q == '0);
  assign mag_ovf     = mag_q[MAGW-1];
  assign mag_hid     = mag_q[MW+3];
  assign e_gt1       = (e_q > EW1'(1));

  // Round to nearest, ties to even; a carry out of the hidden bit renormalizes by one.
  assign rnd_lsb   = mag_q[3];
  assign rnd_g     = mag_q[2];
  assign rnd_rs    = mag_q[1] | mag_q[0];
  assign rnd_inc   = rnd_g & (rnd_rs | rnd_lsb);
  assign f_raw     = {1'b0, mag_q[MW+3:3]} + (MW+2)'(rnd_inc);
  assign f_norm    = f_raw[MW+1] ? f_raw[MW+1:1] : f_raw[MW:0];
  assign e_rnd     = e_q + EW1'(f_raw[MW+1]);
  assign ovf_rnd   = (e_rnd >= {1'b0, {EXP_WIDTH{1'b1}}});
  // Without a hidden bit the value is denormal; if rounding produced the hidden bit, e is already 1.
  assign exp_field = f_norm[MW] ? e_rnd[EXP_WIDTH-1:0] : '0;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (in_valid) state_d = NORM;
      NORM: begin
        if (mag_is_zero)            state_d = ROUND;
        else if (mag_ovf)           state_d = NORM;
        else if (!mag_hid && e_gt1) state_d = NORM;
        else                        state_d = ROUND;
      end
      ROUND: state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mag_q        <= '0;
      e_q          <= '0;
      sgn_q        <= 1'b0;
      zero_q       <= 1'b0;
      out_sign     <= 1'b0;
      out_exp      <= '0;
      out_frac     <= '0;
      out_overflow <= 1'b0;
      out_zero     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          mag_q  <= mag_in;
          sgn_q  <= sign_in ^ sum_neg;
          e_q    <= (exp_in == '0) ? EW1'(1) : {1'b0, exp_in};
          zero_q <= 1'b0;
        end
        NORM: begin
          if (mag_is_zero) begin
            zero_q <= 1'b1;
          end else if (mag_ovf) begin
            mag_q <= {1'b0, mag_q[MAGW-1:2], mag_q[1] | mag_q[0]};
            e_q   <= e_q + EW1'(1);
          end else if (!mag_hid && e_gt1) begin
            mag_q <= mag_q << 1;
            e_q   <= e_q - EW1'(1);
          end
        end
        ROUND: begin
          if (zero_q) begin
            out_sign     <= 1'b0;
            out_exp      <= '0;
            out_frac     <= '0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b1;
          end else if (ovf_rnd) begin
            out_sign     <= sgn_q;
            out_exp      <= '1;
            out_frac     <= '0;
            out_overflow <= 1'b1;
            out_zero     <= 1'b0;
          end else begin
            out_sign     <= sgn_q;
            out_exp      <= exp_field;
            out_frac     <= f_norm[MW-1:0];
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// tb/tb_fp_normalize_round.sv - directed-vector self-checking bench for fp_normalize_round
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [26:0] sum = '0;
  logic        carry = 1'b0;
  logic        sum_neg = 1'b0;
  logic        sign_in = 1'b0;
  logic [7:0]  exp_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_frac;
  logic        out_overflow;
  logic        out_zero;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fp_normalize_round #(.MANTISSA_WIDTH(23), .EXP_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .carry(carry), .sum_neg(sum_neg), .sign_in(sign_in), .exp_in(exp_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp),
    .out_frac(out_frac), .out_overflow(out_overflow), .out_zero(out_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic accept(input logic c, input logic [26:0] s, input logic neg,
                        input logic sg, input logic [7:0] e);
    @(negedge clk);
    carry = c; sum = s; sum_neg = neg; sign_in = sg; exp_in = e; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Latency counts edges from the accept edge to the first edge at which out_valid is seen high.
  task automatic run_op(input string tag, input logic c, input logic [26:0] s, input logic neg,
                        input logic sg, input logic [7:0] e, input int exp_lat,
                        input logic e_sign, input logic [7:0] e_exp, input logic [22:0] e_frac,
                        input logic e_ovf, input logic e_zero, input int hold);
    int lat;
    lat = -1;
    accept(c, s, neg, sg, e);
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = n + 1; break; end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_sign"}, out_sign, e_sign);
    check({tag, "_exp"}, out_exp, e_exp);
    check({tag, "_frac"}, out_frac, e_frac);
    check({tag, "_ovf"}, out_overflow, e_ovf);
    check({tag, "_zero"}, out_zero, e_zero);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_ready"}, in_ready, 1'b0);
      check({tag, "_hold_exp"}, out_exp, e_exp);
      check({tag, "_hold_frac"}, out_frac, e_frac);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    check({tag, "_back_idle"}, in_ready, 1'b1);
  endtask

  initial begin
    #2;
    check("rst_valid", out_valid, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_outs", {out_sign, out_exp, out_frac, out_overflow, out_zero}, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;

    run_op("two",     1'b1, 27'h0000000, 1'b0, 1'b0, 8'd127, 4,  1'b0, 8'd128, 23'h0,      1'b0, 1'b0, 0);
    run_op("lshift",  1'b0, 27'h0000008, 1'b0, 1'b0, 8'd127, 26, 1'b0, 8'd104, 23'h0,      1'b0, 1'b0, 0);
    run_op("denorm",  1'b0, 27'h0000008, 1'b0, 1'b0, 8'd1,   3,  1'b0, 8'd0,   23'h1,      1'b0, 1'b0, 0);
    run_op("tie_odd", 1'b0, 27'h7FFFFFC, 1'b0, 1'b0, 8'd127, 3,  1'b0, 8'd128, 23'h0,      1'b0, 1'b0, 0);
    run_op("tie_evn", 1'b0, 27'h7FFFFF4, 1'b0, 1'b0, 8'd127, 3,  1'b0, 8'd127, 23'h7FFFFE, 1'b0, 1'b0, 0);
    run_op("zero",    1'b0, 27'h0000000, 1'b0, 1'b1, 8'd127, 3,  1'b0, 8'd0,   23'h0,      1'b0, 1'b1, 0);
    // -(27'h4000000) as a 28-bit two's-complement value is 28'hC000000.
    run_op("neg",     1'b1, 27'h4000000, 1'b1, 1'b0, 8'd100, 3,  1'b1, 8'd100, 23'h0,      1'b0, 1'b0, 0);
    run_op("ovf",     1'b1, 27'h0000000, 1'b0, 1'b0, 8'd254, 4,  1'b0, 8'd255, 23'h0,      1'b1, 1'b0, 0);
    run_op("exp0",    1'b0, 27'h4000000, 1'b0, 1'b1, 8'd0,   3,  1'b1, 8'd1,   23'h0,      1'b0, 1'b0, 0);
    run_op("hold",    1'b0, 27'h6000000, 1'b0, 1'b0, 8'd130, 3,  1'b0, 8'd130, 23'h400000, 1'b0, 1'b0, 5);

    accept(1'b0, 27'h0000008, 1'b0, 1'b0, 8'd127);
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 1'b0);
    check("abort_ready", in_ready, 1'b1);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    run_op("post_rst", 1'b0, 27'h2000000, 1'b0, 1'b1, 8'd127, 4, 1'b1, 8'd126, 23'h0, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
